// File: rtl/req_pending_latch.sv
// Edge-triggered request latch feeding a priority encoder: per-source pending bits with
// ack-clear, mask gating on the output, sticky overflow flags and a saturating event counter.
module req_pending_latch (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_in,
  input  logic       mask_wr,
  input  logic [7:0] mask_data,
  input  logic       ack,
  input  logic [2:0] ack_idx,
  input  logic       ovf_clr,
  output logic [7:0] pend_out,
  output logic       pend_valid,
  output logic [7:0] mask_q,
  output logic [7:0] ovf,
  output logic [7:0] evt_cnt
);

  logic [7:0] req_prev_reg;
  logic [7:0] pending_reg, pending_next;
  logic [7:0] ovf_reg, ovf_next;
  logic [7:0] mask_reg;
  logic [7:0] evt_cnt_reg, evt_cnt_next;
  logic [7:0] rise;
  logic [7:0] ack_vec;
  logic [3:0] inc;
  logic [8:0] cnt_sum;

  // Per-source edge detect and pending/overflow update; a same-cycle edge beats its ack.
  for (genvar gi = 0; gi < 8; gi++) begin : g_src
    assign rise[gi]         = req_in[gi] & ~req_prev_reg[gi];
    assign ack_vec[gi]      = ack && (ack_idx == 3'(gi));
    assign pending_next[gi] = rise[gi] | (pending_reg[gi] & ~ack_vec[gi]);
    assign ovf_next[gi]     = (rise[gi] & pending_reg[gi] & ~ack_vec[gi]) |
                              (ovf_reg[gi] & ~ovf_clr);
  end

  always_comb begin
    inc = 4'd0;
    for (int i = 0; i < 8; i++) begin
      inc = inc + {3'b000, rise[i]};
    end
  end

  assign cnt_sum      = {1'b0, evt_cnt_reg} + {5'b00000, inc};
  assign evt_cnt_next = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_prev_reg <= 8'h00;
      pending_reg  <= 8'h00;
      ovf_reg      <= 8'h00;
      evt_cnt_reg  <= 8'h00;
      mask_reg     <= 8'hFF;
    end else begin
      req_prev_reg <= req_in;
      pending_reg  <= pending_next;
      ovf_reg      <= ovf_next;
      evt_cnt_reg  <= evt_cnt_next;
      if (mask_wr) begin
        mask_reg <= mask_data;
      end
    end
  end

  // Outputs depend on registers only, so no input reaches them combinationally.
  assign pend_out   = pending_reg & ~mask_reg;
  assign pend_valid = |pend_out;
  assign mask_q     = mask_reg;
  assign ovf        = ovf_reg;
  assign evt_cnt    = evt_cnt_reg;

endmodule

// File: tb/tb_req_pending_latch.sv
// Scoreboard bench for req_pending_latch: a behavioural model queues the expected outputs
// for each driven cycle, and they are popped and compared once the DUT has clocked.
module tb_req_pending_latch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_in;
  logic       mask_wr;
  logic [7:0] mask_data;
  logic       ack;
  logic [2:0] ack_idx;
  logic       ovf_clr;
  logic [7:0] pend_out;
  logic       pend_valid;
  logic [7:0] mask_q;
  logic [7:0] ovf;
  logic [7:0] evt_cnt;

  typedef struct {
    logic [7:0] pend;
    logic       pv;
    logic [7:0] mask;
    logic [7:0] ovf;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  logic [7:0] m_pend, m_mask, m_ovf, m_prev;
  int         m_cnt;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;

  always #5 clk = ~clk;

  req_pending_latch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_in     (req_in),
    .mask_wr    (mask_wr),
    .mask_data  (mask_data),
    .ack        (ack),
    .ack_idx    (ack_idx),
    .ovf_clr    (ovf_clr),
    .pend_out   (pend_out),
    .pend_valid (pend_valid),
    .mask_q     (mask_q),
    .ovf        (ovf),
    .evt_cnt    (evt_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Drive one cycle, update the model, push the expectation, then compare after the edge.
  task automatic step(input logic rn, input logic [7:0] req, input logic mw,
                      input logic [7:0] md, input logic a, input logic [2:0] ai,
                      input logic oc);
    logic [7:0] np;
    logic [7:0] no;
    int         ncnt;
    exp_t       e;
    exp_t       got;
    rst_n = rn; req_in = req; mask_wr = mw; mask_data = md;
    ack = a; ack_idx = ai; ovf_clr = oc;
    if (!rn) begin
      m_pend = 8'h00; m_ovf = 8'h00; m_cnt = 0; m_prev = 8'h00; m_mask = 8'hFF;
    end else begin
      np = m_pend;
      no = oc ? 8'h00 : m_ovf;
      ncnt = m_cnt;
      if (a) np[ai] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (req[i] && !m_prev[i]) begin
          ncnt++;
          if (m_pend[i] && !(a && ai == 3'(i))) no[i] = 1'b1;
          np[i] = 1'b1;
        end
      end
      if (ncnt > 255) ncnt = 255;
      if (mw) m_mask = md;
      m_pend = np; m_ovf = no; m_cnt = ncnt; m_prev = req;
    end
    e.pend = m_pend & ~m_mask;
    e.pv   = |(m_pend & ~m_mask);
    e.mask = m_mask;
    e.ovf  = m_ovf;
    e.cnt  = 8'(m_cnt);
    sb_q.push_back(e);
    @(posedge clk);
    #2;
    cyc++;
    $display("cyc %0d rst_n=%b req=%h mw=%b md=%h ack=%b idx=%0d clr=%b -> pend_out=%h pv=%b mask=%h ovf=%h cnt=%0d",
             cyc, rn, req, mw, md, a, ai, oc, pend_out, pend_valid, mask_q, ovf, evt_cnt);
    chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      got = sb_q.pop_front();
      chk("pend_out", 32'(pend_out), 32'(got.pend));
      chk("pend_valid", 32'(pend_valid), 32'(got.pv));
      chk("mask_q", 32'(mask_q), 32'(got.mask));
      chk("ovf", 32'(ovf), 32'(got.ovf));
      chk("evt_cnt", 32'(evt_cnt), 32'(got.cnt));
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [7:0] req);
    step(1'b1, req, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_pend = 8'h00; m_mask = 8'hFF; m_ovf = 8'h00; m_prev = 8'h00; m_cnt = 0;
    rst_n = 1'b0; req_in = 8'h00; mask_wr = 1'b0; mask_data = 8'h00;
    ack = 1'b0; ack_idx = 3'd0; ovf_clr = 1'b0;
    @(negedge clk);

    // Reset state and masked-after-reset outputs
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    chk("rst_mask", 32'(mask_q), 32'h0000_00FF);
    chk("rst_valid", 32'(pend_valid), 32'd0);

    // Unmask, single-cycle pulse on bits 0 and 2
    step(1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0);
    idle(8'h05);
    chk("pulse_pend", 32'(pend_out), 32'h05);
    chk("pulse_cnt", 32'(evt_cnt), 32'd2);
    idle(8'h00);

    // Ack bit 2 then bit 0, then a no-op ack of a non-pending bit
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 3'd2, 1'b0);
    chk("ack2_pend", 32'(pend_out), 32'h01);
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0);
    chk("ack0_valid", 32'(pend_valid), 32'd0);
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 3'd5, 1'b0);

    // Overflow on bit 3, then clear it; pending stays set
    idle(8'h08);
    idle(8'h00);
    idle(8'h08);
    chk("ovf3", 32'(ovf), 32'h08);
    idle(8'h08);
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
    chk("ovf_clr", 32'(ovf), 32'h00);
    chk("pend3_kept", 32'(pend_out), 32'h08);

    // Edge and ack on bit 6 in the same cycle: set wins, no overflow
    idle(8'h40);
    idle(8'h00);
    step(1'b1, 8'h40, 1'b0, 8'h00, 1'b1, 3'd6, 1'b0);
    chk("set_wins", 32'(pend_out), 32'h48);
    chk("set_no_ovf", 32'(ovf), 32'h00);

    // Clear 3 and 6, mask bit 7, edge on bit 7 stays hidden until unmasked
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 3'd3, 1'b0);
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 3'd6, 1'b0);
    step(1'b1, 8'h00, 1'b1, 8'h80, 1'b0, 3'd0, 1'b0);
    idle(8'h80);
    chk("masked_pend", 32'(pend_out), 32'h00);
    step(1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0);
    chk("unmask_pend", 32'(pend_out), 32'h80);

    // New overflow beats ovf_clr in the same cycle
    step(1'b1, 8'h80, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
    chk("ovf_beats_clr", 32'(ovf), 32'h80);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'($urandom), ($urandom_range(0, 7) == 0), 8'($urandom),
           1'($urandom), 3'($urandom), ($urandom_range(0, 5) == 0));
    end

    // Saturation: toggle all lines for 70 cycles
    for (int i = 0; i < 70; i++) begin
      idle((i % 2 == 0) ? 8'hFF : 8'h00);
    end
    chk("sat_cnt", 32'(evt_cnt), 32'd255);
    idle(8'hFF);
    chk("sat_hold", 32'(evt_cnt), 32'd255);

    // Reset overrides concurrent inputs and discards state
    step(1'b0, 8'hFF, 1'b1, 8'h00, 1'b1, 3'd1, 1'b0);
    chk("midrst_cnt", 32'(evt_cnt), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'h00);
    chk("midrst_mask", 32'(mask_q), 32'hFF);

    // Line high across reset release counts as an edge
    idle(8'hFF);
    chk("post_rst_edge", 32'(evt_cnt), 32'd8);
    idle(8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/req_pending_latch.md
REQ_PENDING_LATCH -- requirements
Module: req_pending_latch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk is the only clock, rst_n is sampled only on the rising edge of clk, and rst_n=0 resets the block.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 req_in  input  8  level request lines, already synchronous to clk, bit 7 highest priority.
REQ-005 mask_wr  input  1  write strobe for the mask register.
REQ-006 mask_data  input  8  new mask value; 1 = source masked.
REQ-007 ack  input  1  service acknowledge from the downstream priority encoder stage.
REQ-008 ack_idx  input  3  index of the source being acknowledged.
REQ-009 ovf_clr  input  1  clear strobe for the ovf register.
REQ-010 pend_out  output  8  pending & ~mask, driven to the 8-bit input of the priority encoder.
REQ-011 pend_valid  output  1  OR-reduction of pend_out.
REQ-012 mask_q  output  8  current mask register.
REQ-013 ovf  output  8  sticky per-source overflow flags.
REQ-014 evt_cnt  output  8  saturating count of accepted rising edges, all sources.

Function
REQ-015 The block SHALL hold a registered req_prev[7:0] that is loaded with req_in on every clock edge.
REQ-016 A rising edge on source i SHALL be defined as req_in[i]=1 and req_prev[i]=0 at the same clock edge.
REQ-017 A rising edge on source i SHALL set pending[i]; the set is visible on pend_out one cycle after the edge is sampled, provided mask[i]=0.
REQ-018 A level held high SHALL set pending[i] only once.
REQ-019 ack=1 SHALL clear pending[ack_idx] at that clock edge; other bits are unaffected.
REQ-020 When a rising edge and an ack target the same bit in the same cycle, the set SHALL win: pending stays 1 and ovf is not set.
REQ-021 When a rising edge occurs on bit i while pending[i]=1 and bit i is not being acked, ovf[i] SHALL be set; pending[i] stays 1.
REQ-022 ovf bits SHALL be sticky until ovf_clr=1; ovf_clr=1 clears all bits.
REQ-023 When ovf_clr and a new overflow occur in the same cycle, the new overflow SHALL win for that bit.
REQ-024 An ack to a bit that is not pending SHALL have no effect.
REQ-025 mask_wr=1 SHALL load mask_data into mask_q at the clock edge.
REQ-026 Masking SHALL gate pend_out only; masked sources still latch pending, set ovf and count.
REQ-027 Unmasking a source that is pending SHALL assert its pend_out bit in the next cycle.
REQ-028 pend_out and pend_valid SHALL be combinational from the pending and mask registers, with no input-to-output combinational path.
REQ-029 evt_cnt SHALL increment by the number of rising edges accepted in the cycle (0..8), including overflowing edges, and SHALL saturate at 255 without wrapping.
REQ-030 Within a cycle, the increment SHALL be computed at 4-bit width, and the sum SHALL be clamped at 9-bit width.

Reset
REQ-031 On an edge with rst_n=0, pending, ovf, evt_cnt and req_prev SHALL be 0 and mask_q SHALL be 8'hFF (all sources masked).
REQ-032 With mask_q=8'hFF after reset, pend_out SHALL be 0 and pend_valid SHALL be 0.
REQ-033 Reset SHALL override all other inputs in the same cycle.
REQ-034 Reset asserted mid-operation SHALL discard all pending and overflow state.
REQ-035 Because req_prev resets to 0, a req_in line already high at the first edge after reset release SHALL be treated as a rising edge.

Verification
REQ-036 Reset, then mask_wr with 8'h00, then pulse req_in=8'h05 for one cycle -> the next cycle shows pend_out=8'h05, pend_valid=1, evt_cnt=2.
REQ-037 With pending=8'h05, ack with ack_idx=2 -> pend_out=8'h01; then ack with ack_idx=0 -> pend_out=8'h00 and pend_valid=0.
REQ-038 With pending[3]=1, a second rising edge on bit 3 -> ovf=8'h08; then ovf_clr -> ovf=8'h00; pending[3] stays 1 throughout.
REQ-039 With pending[6]=1, ack with ack_idx=6 in the same cycle as a new rising edge on bit 6 -> pending[6]=1 and ovf[6]=0.
REQ-040 With mask=8'h80 and a rising edge on bit 7 -> pend_out=0; then mask_wr with 8'h00 -> pend_out=8'h80 the next cycle.
REQ-041 Toggle req_in between 8'hFF and 8'h00 for 70 cycles -> evt_cnt=255 and held there; rst_n=0 mid-run -> all state returns to the REQ-031 values the next cycle.
